// File: rtl/monolith_bricks_seq.sv
// ---------------------------------------------------------------------------
// monolith_bricks_seq
//
// Folded Monolith "Bricks" layer over the Mersenne-31 field (p = 2^W - 1):
//   state_out[0] = state_in[0]
//   state_out[i] = state_in[i] + state_in[i-1]^2 mod p,  i = 1..STATE_SIZE-1
// All squarings go through one shared, pipelined external multiplier. Lanes
// are issued in ascending order and results come back in issue order, so a
// single write-back pointer is enough to place them. The modular add is local.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   in_valid       upstream offers a state            in_ready  block is idle
//   state_in       input state, STATE_SIZE canonical elements
//   out_valid      state_out holds a finished result  out_ready consumer takes it
//   state_out      result state, canonical
//   mul_valid      operand issue to the multiplier    mul_a/mul_b squared operand
//   mul_res_valid  multiplier result strobe           mul_res   product mod p
//   busy           high whenever the FSM is not IDLE
//   err            sticky: unexpected result strobe, or non-canonical product
// ---------------------------------------------------------------------------
module monolith_bricks_seq #(
  parameter int WORD_WIDTH      = 31,
  parameter int STATE_SIZE      = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_out,
  output logic                                  mul_valid,
  output logic [WORD_WIDTH-1:0]                 mul_a,
  output logic [WORD_WIDTH-1:0]                 mul_b,
  input  logic                                  mul_res_valid,
  input  logic [WORD_WIDTH-1:0]                 mul_res,
  output logic                                  busy,
  output logic                                  err
);

  localparam int IW = (STATE_SIZE > 1) ? $clog2(STATE_SIZE) : 1;
  // Pointers carry one extra bit so the write pointer can step past the last lane.
  localparam int PW = IW + 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [WORD_WIDTH-1:0] P = {WORD_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                                state_q;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] opnd_q;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] out_q;
  logic [PW-1:0]                         iptr_q;
  logic [PW-1:0]                         wptr_q;
  logic [CW-1:0]                         cnt_q;
  logic [CW-1:0]                         cnt_d;
  logic                                  in_ready_q;
  logic                                  out_valid_q;
  logic                                  mul_valid_q;
  logic [WORD_WIDTH-1:0]                 mul_a_q;
  logic                                  busy_q;
  logic                                  err_q;

  logic                                  issue_s;
  logic                                  res_ok_s;
  logic                                  last_wr_s;
  logic [IW-1:0]                         iidx_s;
  logic [IW-1:0]                         widx_s;
  logic [WORD_WIDTH-1:0]                 wsum_s;

  // a + b mod p for a, b < p; a non-canonical b is folded once, never corrected further.
  function automatic logic [WORD_WIDTH-1:0] mod_add(input logic [WORD_WIDTH-1:0] a,
                                                    input logic [WORD_WIDTH-1:0] b);
    logic [WORD_WIDTH:0] s;
    logic [WORD_WIDTH:0] t;
    s = {1'b0, a} + {1'b0, b};
    t = s - {1'b0, P};
    if (s >= {1'b0, P}) begin
      mod_add = t[WORD_WIDTH-1:0];
    end else begin
      mod_add = s[WORD_WIDTH-1:0];
    end
  endfunction

  // A strobe with nothing in flight is stray (e.g. left over from before a reset) and is dropped.
  assign issue_s   = (state_q == ISSUE) && (cnt_q < CW'(MAX_OUTSTANDING));
  assign res_ok_s  = mul_res_valid && (cnt_q != {CW{1'b0}});
  assign last_wr_s = res_ok_s && (wptr_q == PW'(STATE_SIZE - 1));
  // Lane k squares element k-1.
  assign iidx_s    = IW'(iptr_q - PW'(1));
  assign widx_s    = IW'(wptr_q);
  assign wsum_s    = mod_add(opnd_q[widx_s], mul_res);

  // Results-in-flight count: issue and result in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (issue_s && !res_ok_s) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!issue_s && res_ok_s) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control FSM, operand buffer, result write-back and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      opnd_q      <= {(STATE_SIZE*WORD_WIDTH){1'b0}};
      out_q       <= {(STATE_SIZE*WORD_WIDTH){1'b0}};
      iptr_q      <= PW'(1);
      wptr_q      <= PW'(1);
      cnt_q       <= {CW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= {WORD_WIDTH{1'b0}};
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q <= cnt_d;

      if (mul_res_valid && ((cnt_q == {CW{1'b0}}) || (mul_res >= P))) begin
        err_q <= 1'b1;
      end

      if (res_ok_s) begin
        out_q[widx_s] <= wsum_s;
        wptr_q        <= wptr_q + PW'(1);
      end

      case (state_q)
        IDLE: begin
          mul_valid_q <= 1'b0;
          if (in_valid && in_ready_q) begin
            opnd_q      <= state_in;
            out_q[0]    <= state_in[0];
            iptr_q      <= PW'(1);
            wptr_q      <= PW'(1);
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_s) begin
            mul_valid_q <= 1'b1;
            mul_a_q     <= opnd_q[iidx_s];
            iptr_q      <= iptr_q + PW'(1);
            if (iptr_q == PW'(STATE_SIZE - 1)) begin
              state_q <= DRAIN;
            end
          end else begin
            mul_valid_q <= 1'b0;
          end
        end
        DRAIN: begin
          mul_valid_q <= 1'b0;
          if (last_wr_s) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          mul_valid_q <= 1'b0;
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          mul_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign state_out = out_q;
  assign mul_valid = mul_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_a_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: doc/monolith_bricks_seq.md
Name: monolith_bricks_seq

Overview:
Folded, time-multiplexed implementation of the Monolith Bricks layer: state_out[i] = state_in[i] + state_in[i-1]^2 mod p for i≥1, and state_out[0] = state_in[0], with p = 2^31-1.
- One shared M31 multiplier (external, pipelined) does all squarings; the modular add is done internally.
- Sequences lanes through the multiplier, collects results, and hands the permuted state back via valid/ready.
- Sits between the round controller and the shared m31_multiplier instance.

Parameters:
WORD_WIDTH, 31, element width; modulus p = 2^WORD_WIDTH-1.
STATE_SIZE, 16, number of state elements (≥2).
MAX_OUTSTANDING, 8, maximum multiplier results in flight; sizes the tag/pointer logic.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  input state offered.
in_ready  out  1  block can accept a state.
state_in  in  WORD_WIDTH x STATE_SIZE  input state, canonical (< p).
out_valid  out  1  state_out holds a completed result.
out_ready  in  1  consumer accepts the result.
state_out  out  WORD_WIDTH x STATE_SIZE  result state, canonical.
mul_valid  out  1  operand issue to the shared multiplier.
mul_a  out  WORD_WIDTH  multiplier operand A.
mul_b  out  WORD_WIDTH  multiplier operand B (always equal to mul_a).
mul_res_valid  in  1  multiplier result strobe, in issue order.
mul_res  in  WORD_WIDTH  product reduced mod p, canonical.
busy  out  1  high in any state other than IDLE.
err  out  1  sticky protocol error flag.

Behaviour:
- Reset values (asserted asynchronously):
  - FSM = IDLE; in_ready=1; out_valid=0; mul_valid=0; busy=0; err=0.
  - mul_a = mul_b = 0; state_out all 0; issue and write-back pointers = 1; outstanding count = 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture state_in into the operand buffer, copy element 0 to state_out[0], go to ISSUE.
- ISSUE:
  - Each cycle, if outstanding < MAX_OUTSTANDING: mul_valid=1 and mul_a=mul_b=buf[iptr-1]; then iptr++.
  - Otherwise stall issue with mul_valid=0.
  - Lanes are issued in ascending order 1..STATE_SIZE-1.
  - After issuing lane STATE_SIZE-1, go to DRAIN.
- Result collection, in any of ISSUE or DRAIN:
  - On mul_res_valid: state_out[wptr] = buf[wptr] + mul_res mod p; then wptr++.
  - Modular add: s = a + b (WORD_WIDTH+1 bits); result = s - p if s ≥ p, else s. Output is always < p; the value p itself never appears.
- DRAIN: when the final lane has been written (wptr passes STATE_SIZE-1), go to DONE.
- DONE:
  - out_valid=1 and state_out is held stable until out_ready.
  - On out_valid&&out_ready: go to IDLE with in_ready=1 on the next cycle.
  - No back-to-back overlap: the next input is only accepted in IDLE.
- Outstanding counter: +1 on issue, -1 on result. A simultaneous issue and result leaves it unchanged.
- No fixed multiplier latency is assumed; completion is counted purely by mul_res_valid.
- Latency: handshake at cycle T; issues at T+1..T+STATE_SIZE-1 (no stalls); with a multiplier latency of L, out_valid rises at T+STATE_SIZE+L.
- err (sticky until reset) is set when:
  - mul_res_valid arrives with outstanding = 0; the result is ignored;
  - mul_res ≥ p; the value is still written, without correction.
- Reset mid-operation: all state is cleared immediately. Multiplier results still in flight after reset deasserts arrive with outstanding = 0, so they set err and are discarded. The integrator must reset the multiplier alongside this block.
- in_valid arriving in a non-IDLE state is ignored; the upstream holds it.

Test Plan:
- All-zero state_in, multiplier L=3, out_ready=1 → out_valid rises exactly at T+19; every state_out element = 0; mul_valid high for 15 consecutive cycles.
- state_in[i]=i → state_out[0]=0, [1]=1, [2]=3, [3]=7, [15]=15+196=211. Repeat with L=1 and L=6: identical values.
- Wrap-around: state_in[0]=p-1, state_in[1]=p-1, rest 0 → state_out[1]=0 (not p), state_out[2]=1, state_out[0]=p-1.
- Throttling: MAX_OUTSTANDING=2, L=5 → mul_valid never issues with 2 results in flight; results are still correct (state_in[i]=i values above).
- Backpressure: out_ready held low for 10 cycles in DONE → out_valid and state_out remain stable, in_ready=0, and a new in_valid is not accepted. A second state is accepted on the cycle after the release.
- Reset asserted at T+8 → all outputs return to their reset values asynchronously. After release, a fresh input completes correctly; err=1 if stale mul_res_valid pulses arrive, and err=0 if the multiplier was reset too.
